// File: rtl/bsg_round_robin_packet_arbiter.sv
// Packet-aware round-robin arbiter: grants whole packets (header + body beats) from one
// channel at a time, rotating priority only at packet boundaries. Zero-latency datapath.
module bsg_round_robin_packet_arbiter #(
  parameter int els_p       = 4,
  parameter int width_p     = 16,
  parameter int len_width_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [els_p*width_p-1:0]   data_i,
  input  logic [els_p-1:0]           v_i,
  output logic [els_p-1:0]           ready_o,
  output logic [width_p-1:0]         data_o,
  output logic                       v_o,
  input  logic                       ready_i,
  output logic [els_p-1:0]           grant_o,
  output logic [$clog2(els_p)-1:0]   tag_o
);

  localparam int tag_w = $clog2(els_p);
  localparam logic [tag_w:0] els_w = (tag_w+1)'(els_p);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state_r, state_n;
  logic [tag_w-1:0]       last_r, last_n;
  logic [tag_w-1:0]       owner_r, owner_n;
  logic [len_width_p-1:0] remain_r, remain_n;

  logic [tag_w-1:0]       sel, cand_tag;
  logic [tag_w:0]         cand_sum;
  logic                   has_sel, sel_v, hs;
  logic [els_p-1:0]       sel_oh;
  logic [width_p-1:0]     sel_data;
  logic [len_width_p-1:0] hdr_len;

  // Selection: owner while locked, otherwise first valid channel after last_r (wrapping).
  always_comb begin
    sel      = '0;
    has_sel  = 1'b0;
    sel_v    = 1'b0;
    cand_sum = '0;
    cand_tag = '0;
    if (state_r == LOCKED) begin
      sel     = owner_r;
      has_sel = 1'b1;
      sel_v   = v_i[owner_r];
    end else begin
      for (int i = 1; i <= els_p; i++) begin
        cand_sum = {1'b0, last_r} + (tag_w+1)'(i);
        if (cand_sum >= els_w) cand_sum = cand_sum - els_w;
        cand_tag = cand_sum[tag_w-1:0];
        if (!has_sel && v_i[cand_tag]) begin
          sel     = cand_tag;
          has_sel = 1'b1;
          sel_v   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int c = 0; c < els_p; c++)
      if (sel == tag_w'(c)) sel_data = data_i[c*width_p +: width_p];
  end

  always_comb begin
    sel_oh      = '0;
    sel_oh[sel] = 1'b1;
  end

  // Everything is gated off while reset is asserted.
  assign v_o     = reset_n_i & sel_v;
  assign data_o  = v_o ? sel_data : '0;
  assign grant_o = (reset_n_i && has_sel) ? sel_oh : '0;
  assign tag_o   = (reset_n_i && has_sel) ? sel : '0;
  assign ready_o = (reset_n_i && has_sel && ready_i) ? sel_oh : '0;
  assign hs      = v_o & ready_i;
  assign hdr_len = sel_data[len_width_p-1:0];

  always_comb begin
    state_n  = state_r;
    last_n   = last_r;
    owner_n  = owner_r;
    remain_n = remain_r;
    unique case (state_r)
      IDLE: begin
        if (hs) begin
          if (hdr_len == '0) begin
            last_n = sel;
          end else begin
            state_n  = LOCKED;
            owner_n  = sel;
            remain_n = hdr_len;
          end
        end
      end
      LOCKED: begin
        // Body beats never feed the length field; only the countdown matters here.
        if (hs && remain_r != '0) begin
          remain_n = remain_r - len_width_p'(1);
          if (remain_r == len_width_p'(1)) begin
            state_n = IDLE;
            last_n  = owner_r;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r  <= IDLE;
      last_r   <= tag_w'(els_p - 1);
      owner_r  <= '0;
      remain_r <= '0;
    end else begin
      state_r  <= state_n;
      last_r   <= last_n;
      owner_r  <= owner_n;
      remain_r <= remain_n;
    end
  end

endmodule

// File: tb/tb_bsg_round_robin_packet_arbiter.sv
// Bench for bsg_round_robin_packet_arbiter: vector table, directed packet sequences and
// randomized traffic checked against a packet-level reference model.
module tb_bsg_round_robin_packet_arbiter;
  localparam int N = 4, W = 16, L = 4;

  logic         clk = 1'b0;
  logic         rst_n, rdy, v_o;
  logic [N*W-1:0] data;
  logic [N-1:0] v, ready_o, grant_o;
  logic [W-1:0] data_o;
  logic [1:0]   tag_o;
  logic [W-1:0] ch_data [N];

  int n_cmp = 0, n_bad = 0;
  bit m_locked;
  int m_owner, m_remain, m_last, e_sel;
  logic e_v, hs_seen;
  int hs_tag, cnt;

  always #5 clk = ~clk;
  always_comb for (int c = 0; c < N; c++) data[c*W +: W] = ch_data[c];

  bsg_round_robin_packet_arbiter #(.els_p(N), .width_p(W), .len_width_p(L)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(data), .v_i(v), .ready_o(ready_o),
    .data_o(data_o), .v_o(v_o), .ready_i(rdy), .grant_o(grant_o), .tag_o(tag_o));

  typedef struct {
    logic [3:0] v; logic [3:0] len; logic rdy; int tag; logic vo; logic [3:0] rdyo;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_lens(input logic [3:0] l0, l1, l2, l3);
    logic [3:0] ls [N];
    ls = '{l0, l1, l2, l3};
    for (int c = 0; c < N; c++) ch_data[c] = {4'(c), 8'h5A, ls[c]};
  endtask

  // Expected outputs from the packet-level model; compared mid-cycle.
  task automatic eval();
    int c;
    @(negedge clk);
    e_sel = -1;
    if (rst_n) begin
      if (m_locked) e_sel = m_owner;
      else for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (e_sel < 0 && v[c]) e_sel = c;
      end
    end
    e_v = (e_sel >= 0) ? v[e_sel] : 1'b0;
    chk("v_o", v_o, e_v);
    chk("tag_o", tag_o, (e_sel < 0) ? 0 : e_sel);
    chk("grant_o", grant_o, (e_sel < 0) ? 0 : (1 << e_sel));
    chk("ready_o", ready_o, (e_sel >= 0 && rdy) ? (1 << e_sel) : 0);
    chk("data_o", data_o, e_v ? ch_data[e_sel] : 0);
    hs_seen = v_o & rdy;
    hs_tag  = tag_o;
  endtask

  task automatic adv();
    int len;
    if (!rst_n) begin
      m_locked = 0; m_last = N - 1; m_owner = 0; m_remain = 0;
    end else if (e_v && rdy) begin
      if (!m_locked) begin
        len = ch_data[e_sel][L-1:0];
        if (len == 0) m_last = e_sel;
        else begin m_locked = 1; m_owner = e_sel; m_remain = len; end
      end else begin
        m_remain--;
        if (m_remain == 0) begin m_locked = 0; m_last = m_owner; end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic cycle();
    eval();
    adv();
  endtask

  task automatic count_cycle(input int ch);
    eval();
    if (hs_seen && hs_tag == ch) cnt++;
    adv();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{4'hF, 4'h0, 1'b1, i % 4, 1'b1, 4'(1 << (i % 4))};
    tbl[8]  = '{4'h0, 4'h0, 1'b1, 0, 1'b0, 4'b0000};
    tbl[9]  = '{4'hF, 4'h0, 1'b0, 0, 1'b1, 4'b0000};
    tbl[10] = '{4'hF, 4'h0, 1'b1, 0, 1'b1, 4'b0001};
    tbl[11] = '{4'h9, 4'h0, 1'b1, 3, 1'b1, 4'b1000};
    tbl[12] = '{4'h5, 4'h0, 1'b1, 0, 1'b1, 4'b0001};

    // Reset with all channels requesting
    rst_n = 1'b0; v = 4'hF; rdy = 1'b1; set_lens(0, 0, 0, 0);
    m_locked = 0; m_last = N - 1; m_owner = 0; m_remain = 0;
    cycle();
    eval();
    chk("rst_v_o", v_o, 1'b0);
    chk("rst_ready_o", ready_o, 4'b0);
    chk("rst_grant_o", grant_o, 4'b0);
    adv();
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      v = tbl[i].v; rdy = tbl[i].rdy;
      set_lens(tbl[i].len, tbl[i].len, tbl[i].len, tbl[i].len);
      eval();
      chk($sformatf("tbl%0d_tag", i), tag_o, tbl[i].tag);
      chk($sformatf("tbl%0d_v", i), v_o, tbl[i].vo);
      chk($sformatf("tbl%0d_ready", i), ready_o, tbl[i].rdyo);
      adv();
    end

    // ch2 packet of 4 beats must not be interrupted
    set_lens(0, 0, 3, 0); rdy = 1'b1; cnt = 0;
    v = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      eval();
      chk("lock_ready", ready_o, 4'b0100);
      if (hs_seen && hs_tag == 2) cnt++;
      adv();
      v = 4'hF;
    end
    chk("lock_beats", cnt, 4);
    eval(); chk("lock_next_tag", tag_o, 3); adv();

    // ch1 packet with owner bubble and backpressure
    set_lens(0, 2, 0, 0); cnt = 0;
    v = 4'b0010; count_cycle(1);
    v = 4'b1101;
    eval(); chk("bubble_v_o", v_o, 1'b0); chk("bubble_grant", grant_o, 4'b0010); adv();
    v = 4'hF; rdy = 1'b0;
    eval(); chk("bp_v_o", v_o, 1'b1); chk("bp_ready", ready_o, 4'b0); adv();
    rdy = 1'b1;
    count_cycle(1);
    count_cycle(1);
    chk("bubble_beats", cnt, 3);
    eval(); chk("bubble_next_tag", tag_o, 2); adv();

    // Maximum-length packet on ch0
    set_lens(4'hF, 0, 0, 0); cnt = 0;
    v = 4'b0001; count_cycle(0);
    v = 4'hF;
    for (int i = 0; i < 15; i++) count_cycle(0);
    chk("max_beats", cnt, 16);
    eval(); chk("max_next_tag", tag_o, 1); adv();

    // Reset in the middle of a ch3 packet
    set_lens(0, 0, 0, 5);
    v = 4'b1000; cycle(); cycle();
    rst_n = 1'b0; v = 4'b1001; cycle();
    rst_n = 1'b1;
    eval(); chk("midrst_tag", tag_o, 0); chk("midrst_v", v_o, 1'b1); adv();

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      v     = 4'($urandom);
      rdy   = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++)
        ch_data[c] = {12'($urandom), ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3))};
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
